calc_status_unit: RTL
=====================

// Module: calc_status_unit
// PURPOSE
//  Calculation-stage responder on the controller's status handshake: watches the controller's
//  2-bit state and answers on a 2-bit CS code (00 busy/not-ready, 01 ready, 10 done).
//  On state==Scal it latches two unsigned operands, runs a W-cycle shift-add multiply,
//  and reports CS=10 with the product held. Sits beside the controller; drives its CS input.
// PARAMETERS
//  W       8    operand width; product width is 2*W; multiply takes exactly W iterations
//  SCAL    1    controller state code that starts a calculation
//  SINIT   0    controller state code that re-arms the unit
// PORTS
//  clk      in   1     single clock, all logic on posedge
//  rst      in   1     synchronous, active-high reset
//  state    in   2     controller state (0 Sinit, 1 Scal, 2 Sdisplay, 3 Slast)
//  op_a     in   W     multiplicand, sampled only on the start edge
//  op_b     in   W     multiplier, sampled only on the start edge
//  CS       out  2     status code to controller: 00 busy/not-ready, 01 ready, 10 done, 11 never
//  result   out  2W    product; valid whenever CS==10
// BEHAVIOUR
//  - FSM: IDLE(CS=00) -> READY(CS=01) -> BUSY(CS=00) -> DONE(CS=10). CS is registered.
//  - Reset (rst high at an edge): FSM=IDLE, CS=00, result=0, counter=0, operand regs=0.
//  - IDLE: unconditionally -> READY at the next edge (CS=01 one cycle after rst drops).
//  - READY: at edge E0 with state==SCAL: latch op_a/op_b, clear accumulator, counter=0 -> BUSY.
//    state==2 or 3 in READY: ignored, stay READY.
//  - BUSY: edges E1..EW each do one iteration: if multiplier LSB set, acc += multiplicand<<i;
//    multiplier >>= 1; counter++. At EW: result<=acc (final), CS<=10, -> DONE.
//    Latency: CS==10 first visible after edge EW (W edges after start edge E0).
//    No early exit: zero operands still take W iterations.
//  - BUSY abort: state==SINIT sampled in BUSY -> READY, CS=01, result unchanged.
//    state==2/3 in BUSY: ignored, iteration continues.
//  - DONE: hold CS=10 and result while state is 1, 2 or 3 (controller needs 10 to advance
//    and may stay in Slast indefinitely). state==SINIT -> READY, CS=01; result held until next
//    start edge.
//  - Arithmetic: accumulator is 2W bits; max W=8 product 255*255=65025 fits, no overflow.
//  - rst wins over every other event at the same edge, including mid-BUSY.
//  - CS never takes value 11.
// CONFIGURATION
//  CALC_SIGNED_EN defined: op_a/op_b are two's complement. On E0 latch magnitudes
//    and sign = a[W-1]^b[W-1]; at EW result <= sign ? -acc : acc (2W-bit two's complement).
//    Latency unchanged. The most-negative operand (-2^(W-1)) uses its magnitude 2^(W-1),
//    correct in 2W bits.
//  CALC_SIGNED_EN undefined: unsigned only, no sign logic synthesised.
// TESTING
//  1. rst=1 two cycles, release -> CS=00,result=0 during reset; CS=01 one edge after release.
//  2. READY, op_a=13, op_b=11, state=1 -> CS=00 for 8 cycles, then CS=10, result=143; held
//     through state=2,3.
//  3. op_a=255, op_b=255, state=1 -> after 8 iterations CS=10, result=65025; then state=0 ->
//     CS=01, result stays 65025.
//  4. Start with op_a=7,op_b=9; at iteration 4 drive state=0 -> CS=01 next edge; restart
//     with op_a=0,op_b=200 -> CS=10 after 8 edges, result=0.
//  5. Mid-BUSY rst=1 at iteration 5 -> CS=00,result=0 next edge, READY one edge after release;
//     state=2 while READY -> CS stays 01.
//  6. CALC_SIGNED_EN: op_a=-3 (8'hFD), op_b=7 -> result=16'hFFEB (-21);
//     op_a=-128, op_b=-128 -> 16'h4000.

Source files
------------

// File: rtl/calc_status_unit.sv
// calc_status_unit: status-handshake responder for the controller's calculation stage.
// Watches the controller state, runs a W-iteration shift-add multiply on request and
// reports busy/ready/done on CS with the product held on result.
// Optional feature: define CALC_SIGNED_EN for two's-complement operands (sign-magnitude
// internally, product negated at the final iteration). Default build is unsigned only.
module calc_status_unit #(
    parameter int unsigned W     = 8,
    parameter logic [1:0]  SCAL  = 2'd1,
    parameter logic [1:0]  SINIT = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       state,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic [1:0]       CS,
    output logic [2*W-1:0]   result
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] CS_BUSY  = 2'b00;
    localparam logic [1:0] CS_READY = 2'b01;
    localparam logic [1:0] CS_DONE  = 2'b10;

    logic [1:0]    fsm_q,    fsm_d;
    logic [1:0]    cs_q,     cs_d;
    logic [PW-1:0] result_q, result_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [W-1:0]  mcand_q,  mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [PW-1:0] acc_q,    acc_d;
    logic [PW-1:0] addend;
    logic [PW-1:0] acc_next;
    logic [PW-1:0] final_val;
    logic [W-1:0]  start_a;
    logic [W-1:0]  start_b;
`ifdef CALC_SIGNED_EN
    logic          sign_q,   sign_d;
`endif

    assign CS     = cs_q;
    assign result = result_q;

    // Operand capture: magnitudes and product sign in signed builds, raw values otherwise
`ifdef CALC_SIGNED_EN
    always_comb begin
        start_a = op_a[W-1] ? W'(~op_a + W'(1)) : op_a;
        start_b = op_b[W-1] ? W'(~op_b + W'(1)) : op_b;
    end
`else
    always_comb begin
        start_a = op_a;
        start_b = op_b;
    end
`endif

    // One shift-add step and the value committed to result on the last iteration
    always_comb begin
        addend   = mplier_q[0] ? (PW'(mcand_q) << cnt_q) : '0;
        acc_next = acc_q + addend;
`ifdef CALC_SIGNED_EN
        final_val = sign_q ? PW'(~acc_next + PW'(1)) : acc_next;
`else
        final_val = acc_next;
`endif
    end

    // Next-state and next-output logic for the handshake FSM and multiplier datapath
    always_comb begin
        fsm_d    = fsm_q;
        cs_d     = cs_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`ifdef CALC_SIGNED_EN
        sign_d   = sign_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                fsm_d = S_READY;
                cs_d  = CS_READY;
            end
            S_READY: begin
                if (state == SCAL) begin
                    mcand_d  = start_a;
                    mplier_d = start_b;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef CALC_SIGNED_EN
                    sign_d   = op_a[W-1] ^ op_b[W-1];
`endif
                    fsm_d    = S_BUSY;
                    cs_d     = CS_BUSY;
                end
            end
            S_BUSY: begin
                // Re-arm request takes priority over the iteration, result untouched
                if (state == SINIT) begin
                    fsm_d = S_READY;
                    cs_d  = CS_READY;
                end else begin
                    acc_d    = acc_next;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        result_d = final_val;
                        fsm_d    = S_DONE;
                        cs_d     = CS_DONE;
                    end
                end
            end
            S_DONE: begin
                if (state == SINIT) begin
                    fsm_d = S_READY;
                    cs_d  = CS_READY;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                cs_d  = CS_BUSY;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            cs_q     <= CS_BUSY;
            result_q <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`ifdef CALC_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            cs_q     <= cs_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`ifdef CALC_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

endmodule
